// File: rtl/eluks_arb_pkg.sv
// Shared types and helpers for the ELUKS read arbiter: FSM states, byte width
// and a one-hot decoder for requester indices.
package eluks_arb_pkg;

  localparam int BYTE_W  = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [3:0] {
    IDLE,
    RST_SPI,
    INIT_ELUKS,
    WAIT_HDR,
    ARB,
    CHECK,
    ISSUE,
    GAP,
    WAIT_BYTE,
    RELEASE,
    ERROR
  } state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around. The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int cand;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/eluks_read_arbiter.sv
// Brings up the SPI/ELUKS pair once after reset, then shares the ELUKS
// decrypted-byte interface among N_REQ requesters in whole round-robin transfers.
module eluks_read_arbiter
  import eluks_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   spi_ctl,
  output logic                   rst_spi,
  output logic                   rst_eluks,
  input  logic                   spi_busy,
  output logic                   r_byte,
  input  logic [BYTE_W-1:0]      eluks_data,
  input  logic                   eluks_busy,
  input  logic                   eluks_error,
  input  logic                   end_eluks_header,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  output logic [N_REQ-1:0]       grant,
  output logic [BYTE_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic [N_REQ-1:0]       done,
  output logic                   ready,
  output logic                   error
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [BYTE_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  logic                arb_found;
  logic [IDX_W-1:0]    arb_idx;
  logic [N_REQ-1:0]    owner_oh;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req   (req),
    .ptr   (ptr_q),
    .found (arb_found),
    .idx   (arb_idx)
  );

  assign owner_oh = N_REQ'(onehot(3'(owner_q)));
  assign spi_ctl  = 1'b1;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // NOTE: registers take non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rst_spi     = 1'b0;
    rst_eluks   = 1'b0;
    r_byte      = 1'b0;
    ready       = 1'b0;
    error       = 1'b0;
    grant       = '0;
    done        = '0;

    case (state_q)
      IDLE: begin
        rst_eluks = 1'b1;
        state_d   = RST_SPI;
      end
      RST_SPI: begin
        rst_eluks = 1'b1;
        rst_spi   = 1'b1;
        state_d   = INIT_ELUKS;
      end
      INIT_ELUKS: begin
        rst_eluks = spi_busy;
        if (!spi_busy) state_d = WAIT_HDR;
      end
      WAIT_HDR: begin
        if (end_eluks_header && !eluks_busy) state_d = ARB;
      end
      ARB: begin
        ready = 1'b1;
        if (arb_found) begin
          owner_d     = arb_idx;
          remaining_d = req_len[int'(arb_idx)*LEN_W +: LEN_W];
          state_d     = CHECK;
        end
      end
      CHECK: begin
        ready   = 1'b1;
        grant   = owner_oh;
        state_d = (remaining_q == '0) ? RELEASE : ISSUE;
      end
      ISSUE: begin
        ready       = 1'b1;
        grant       = owner_oh;
        r_byte      = 1'b1;
        remaining_d = remaining_q - LEN_W'(1);
        state_d     = GAP;
      end
      GAP: begin
        // ELUKS raises busy one cycle after r_byte, so busy is not trusted here.
        ready   = 1'b1;
        grant   = owner_oh;
        state_d = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        ready = 1'b1;
        grant = owner_oh;
        if (!eluks_busy) begin
          rd_data_d  = eluks_data;
          rd_valid_d = 1'b1;
          state_d    = CHECK;
        end
      end
      RELEASE: begin
        ready   = 1'b1;
        done    = owner_oh;
        ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d = ARB;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A fatal ELUKS error wins over every transition once the SPI reset is out.
    if (eluks_error && !(state_q inside {IDLE, RST_SPI})) begin
      state_d    = ERROR;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
    end
  end

endmodule

// File: tb/tb_eluks_read_arbiter.sv
// Scoreboard bench for eluks_read_arbiter with small SPI, header and ELUKS byte models.
module tb_eluks_read_arbiter;

  localparam int N_REQ    = 2;
  localparam int LEN_W    = 16;
  localparam int BUSY_CYC = 5;
  localparam int SPI_CYC  = 10;
  localparam int HDR_CYC  = 40;

  typedef struct {
    logic [N_REQ-1:0] owner;
    logic [7:0]       data;
  } sb_t;

  logic                   clk;
  logic                   rst;
  logic                   spi_ctl, rst_spi, rst_eluks, spi_busy, r_byte;
  logic [7:0]             eluks_data;
  logic                   eluks_busy, eluks_error, end_eluks_header;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic [N_REQ-1:0]       grant, done;
  logic [7:0]             rd_data;
  logic                   rd_valid, ready, error;

  eluks_read_arbiter #(.N_REQ(N_REQ), .LEN_W(LEN_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .spi_ctl          (spi_ctl),
    .rst_spi          (rst_spi),
    .rst_eluks        (rst_eluks),
    .spi_busy         (spi_busy),
    .r_byte           (r_byte),
    .eluks_data       (eluks_data),
    .eluks_busy       (eluks_busy),
    .eluks_error      (eluks_error),
    .end_eluks_header (end_eluks_header),
    .req              (req),
    .req_len          (req_len),
    .grant            (grant),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .done             (done),
    .ready            (ready),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  sb_t              sb_q[$];
  logic [N_REQ-1:0] exp_grant_q[$];
  logic [N_REQ-1:0] cur_owner = '0;
  logic [N_REQ-1:0] prev_grant = '0;
  logic             in_xfer = 1'b0;
  int cyc = 0, hdr_cnt = 0, busy_cnt = 0, spi_cnt = 0;
  int n_rbyte = 0, n_done = 0, grants_left = 0;
  int grant_tick = 0, done_tick = 0;
  int rst_spi_cnt = 0, eluks_low_tick = -1, ready_tick = -1, spi_fall_tick = -1;
  logic [7:0] data_ctr = 8'h00, pend_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample/score DUT outputs at +1, then advance the input models.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    hdr_cnt = rst ? 0 : hdr_cnt + 1;

    if (rst) begin
      in_xfer    = 1'b0;
      prev_grant = '0;
    end else begin
      if (rst_spi) rst_spi_cnt++;
      if (!rst_eluks && eluks_low_tick < 0) eluks_low_tick = hdr_cnt;
      if (ready && ready_tick < 0) ready_tick = hdr_cnt;
      if (prev_grant == '0 && grant != '0) begin
        check("done_before_grant", 32'(in_xfer), 0);
        if (exp_grant_q.size() == 0) check("grant_unexpected", 32'(grant), 0);
        else begin
          cur_owner = exp_grant_q.pop_front();
          check("grant_owner", 32'(grant), 32'(cur_owner));
        end
        in_xfer    = 1'b1;
        grant_tick = cyc;
        if (grants_left > 0) begin
          grants_left--;
          if (grants_left == 0) req = '0;
        end
      end
      if (rd_valid) begin
        if (sb_q.size() == 0) check("rd_unexpected", 32'(rd_valid), 0);
        else begin
          e = sb_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e.data));
          check("rd_owner", 32'(grant), 32'(e.owner));
        end
      end
      if (done != '0) begin
        check("done_owner", 32'(done), 32'(cur_owner));
        check("grant_at_done", 32'(grant), 0);
        in_xfer   = 1'b0;
        n_done++;
        done_tick = cyc;
      end
      if (r_byte) n_rbyte++;
      prev_grant = grant;
    end

    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        eluks_busy = 1'b0;
        eluks_data = pend_data;
      end
    end
    if (!rst && r_byte) begin
      eluks_busy = 1'b1;
      busy_cnt   = BUSY_CYC;
      pend_data  = data_ctr;
      sb_q.push_back('{owner: cur_owner, data: data_ctr});
      data_ctr++;
    end
    if (spi_cnt > 0) begin
      spi_cnt--;
      if (spi_cnt == 0) begin
        spi_busy      = 1'b0;
        spi_fall_tick = hdr_cnt;
      end
    end
    if (!rst && rst_spi) begin
      spi_busy = 1'b1;
      spi_cnt  = SPI_CYC;
    end
    end_eluks_header = !rst && (hdr_cnt >= HDR_CYC);
  endtask

  task automatic check_reset();
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_r_byte", 32'(r_byte), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_error", 32'(error), 0);
    check("rst_rst_spi", 32'(rst_spi), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rst_eluks", 32'(rst_eluks), 1);
  endtask

  task automatic reset_and_bringup();
    rst         = 1'b1;
    req         = '0;
    eluks_error = 1'b0;
    repeat (3) tick();
    check_reset();
    rst_spi_cnt    = 0;
    eluks_low_tick = -1;
    ready_tick     = -1;
    spi_fall_tick  = -1;
    rst            = 1'b0;
    for (int i = 0; i < 200 && ready_tick < 0; i++) tick();
    check("bringup_rst_spi_cycles", 32'(rst_spi_cnt), 1);
    check("bringup_rst_eluks_release", 32'(eluks_low_tick), 32'(spi_fall_tick + 1));
    check("bringup_ready_tick", 32'(ready_tick), 32'(HDR_CYC + 1));
    check("spi_ctl", 32'(spi_ctl), 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && n_done < target; i++) tick();
    check("done_count", 32'(n_done), 32'(target));
  endtask

  task automatic wait_rbyte(input int target, input int budget);
    for (int i = 0; i < budget && n_rbyte < target; i++) tick();
    check("rbyte_count_reached", 32'(n_rbyte), 32'(target));
  endtask

  task automatic start_xfer(input logic [N_REQ-1:0] r, input int len0, input int len1,
                            input int n_grants, input logic [7:0] base);
    data_ctr = base;
    n_rbyte  = 0;
    n_done   = 0;
    req_len[0*LEN_W +: LEN_W] = LEN_W'(len0);
    req_len[1*LEN_W +: LEN_W] = LEN_W'(len1);
    grants_left = n_grants;
    req         = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; spi_busy = 1'b0; eluks_data = 8'h00; eluks_busy = 1'b0;
    eluks_error = 1'b0; end_eluks_header = 1'b0; req = '0; req_len = '0;

    reset_and_bringup();

    // Single transfer of four bytes to requester 0.
    exp_grant_q.push_back(2'b01);
    start_xfer(2'b01, 4, 0, 1, 8'hA0);
    wait_done(1, 300);
    check("single_rbyte", 32'(n_rbyte), 4);
    check("single_sb_drained", 32'(sb_q.size()), 0);
    tick();
    check("single_grant_after", 32'(grant), 0);

    // Zero-length transfer to requester 1.
    exp_grant_q.push_back(2'b10);
    start_xfer(2'b10, 0, 0, 1, 8'hF0);
    wait_done(1, 50);
    check("zero_rbyte", 32'(n_rbyte), 0);
    check("zero_done_latency", 32'((done_tick - grant_tick) <= 3), 1);

    // Both requesting: pointer is back at 0, so grants alternate starting with 0.
    exp_grant_q.push_back(2'b01);
    exp_grant_q.push_back(2'b10);
    exp_grant_q.push_back(2'b01);
    exp_grant_q.push_back(2'b10);
    start_xfer(2'b11, 2, 2, 4, 8'hB0);
    wait_done(4, 400);
    check("rr_rbyte", 32'(n_rbyte), 8);
    check("rr_sb_drained", 32'(sb_q.size()), 0);
    check("rr_grants_used", 32'(exp_grant_q.size()), 0);
    tick();

    // Error while waiting for byte 2 of 5.
    exp_grant_q.push_back(2'b01);
    start_xfer(2'b01, 5, 0, 1, 8'hC0);
    wait_rbyte(2, 200);
    tick();
    tick();
    eluks_error = 1'b1;
    tick();
    check("err_error", 32'(error), 1);
    check("err_grant", 32'(grant), 0);
    check("err_ready", 32'(ready), 0);
    check("err_done", 32'(done), 0);
    eluks_error = 1'b0;
    repeat (6) tick();
    check("err_sticky", 32'(error), 1);
    check("err_still_not_ready", 32'(ready), 0);
    check("err_no_done", 32'(n_done), 0);
    check("err_byte2_undelivered", 32'(sb_q.size()), 1);
    sb_q.delete();
    reset_and_bringup();

    // Reset asserted during ISSUE.
    exp_grant_q.push_back(2'b01);
    start_xfer(2'b01, 3, 0, 1, 8'hD0);
    wait_rbyte(1, 100);
    rst = 1'b1;
    req = '0;
    tick();
    check_reset();
    sb_q.delete();
    exp_grant_q.delete();
    reset_and_bringup();
    check("midrst_no_done", 32'(n_done), 0);

    // Service resumes after the second bring-up.
    exp_grant_q.push_back(2'b01);
    start_xfer(2'b01, 1, 0, 1, 8'hE0);
    wait_done(1, 100);
    check("resume_rbyte", 32'(n_rbyte), 1);
    check("resume_sb_drained", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
